mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single main-memory port between instruction fetch and the data cache's miss/store path. Each requester holds a request until granted. The arbiter serialises one transaction at a time to memory, using round-robin on conflicts. It returns read data to the owner with a one-cycle valid pulse and keeps grant and conflict statistics for performance analysis. It sits between the core's fetch/cache blocks and `data_mem`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `i_req`  in  1  instruction-fetch request, held until `i_gnt`
- `i_addr`  in  ADDR_WIDTH  fetch address
- `i_gnt`  out  1  one-cycle pulse: fetch request accepted
- `i_rvalid`  out  1  one-cycle pulse: `i_rdata` valid
- `i_rdata`  out  DATA_WIDTH  fetch read data
- `d_req`  in  1  data request, held until `d_gnt`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_WIDTH  data address
- `d_wdata`  in  DATA_WIDTH  write data
- `d_gnt`  out  1  one-cycle pulse: data request accepted
- `d_rvalid`  out  1  one-cycle pulse: transaction complete; `d_rdata` valid for reads
- `d_rdata`  out  DATA_WIDTH  data read data
- `mem_req`  out  1  memory transaction active
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_ready`  in  1  memory completes current transaction this cycle
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid with `mem_ready`
- `grants_i`, `grants_d`, `conflicts`  out  32 each  statistics counters

## Operation
- FSM states: ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D.
- Requests are sampled only in ARB_IDLE.
- ARB_IDLE transitions:
  - only `i_req` → ARB_BUSY_I
  - only `d_req` → ARB_BUSY_D
  - both → the requester not granted last; `conflicts` increments
  - none → stay in ARB_IDLE
- Round-robin pointer `last_d`, reset 0. Fetch wins the first conflict after reset.
- On entering ARB_BUSY_x, latch that requester's addr, we and wdata. Instruction fetches always use we=0.
- Assert `x_gnt` for exactly the first cycle of ARB_BUSY_x. `grants_x` increments.
- ARB_BUSY_x:
  - `mem_req`=1; `mem_we`/`mem_addr`/`mem_wdata` come from the latches and are stable until `mem_ready`.
  - `mem_ready`=1 → next cycle: `x_rvalid`=1 and `x_rdata`=registered `mem_rdata`; state → ARB_IDLE. For writes, `d_rdata`=0.
- Statistics counters saturate at 0xFFFF_FFFF and do not wrap.

## Timing
- Reset values:
  - all outputs 0; `mem_addr`/`mem_wdata`/rdata registers 0
  - state ARB_IDLE, `last_d`=0, counters 0
- Asserting `reset` mid-transaction drops `mem_req` immediately (asynchronous). The in-flight transaction is abandoned with no `rvalid`.
- Latency, with request at cycle N:
  - `gnt` and first `mem_req` cycle: N+1
  - `mem_ready` at cycle M≥N+1 → `rvalid` at M+1
  - back in ARB_IDLE at M+1, where new requests are sampled; the next `gnt` is at M+2
  - minimum 3 cycles per transaction
- A request withdrawn before being granted is legal: no grant, no counter change.
- Requests present during ARB_BUSY are ignored, not queued; the requester must keep holding.
- `mem_ready` in ARB_IDLE is ignored.
- `mem_ready` on the first busy cycle is legal.
- Only one of `i_gnt`/`d_gnt` and one of `i_rvalid`/`d_rvalid` may be high in any cycle.
- Counters increment on the same edge the state enters ARB_BUSY.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D)
  - requester-id constants `REQ_I`=0, `REQ_D`=1
  - counter width constant 32
- Sub-module `arb_rr2`: combinational 2-way round-robin pick.
  - inputs: `req[1:0]`, `last_d`
  - outputs: `pick`, `conflict`
- FSM, latches and counters live in `mem_arbiter`.

## Test plan
- Reset, then `i_req`, `i_addr`=0x100 at cycle 2, and `mem_ready` with `mem_rdata`=0xDEADBEEF at cycle 5:
  - `i_gnt` at cycle 3
  - `mem_addr`=0x100 during cycles 3–5
  - `i_rvalid` with `i_rdata`=0xDEADBEEF at cycle 6
  - `grants_i`=1
- `i_req` and `d_req` raised together and held continuously, `mem_ready` on every busy cycle:
  - grant order I, D, I, D
  - `conflicts`=4 after four transactions
- `d_req` write, `d_addr`=0x20, `d_wdata`=0x12345678:
  - `mem_we`=1 with both values latched
  - `d_rvalid` with `d_rdata`=0
  - `i_rvalid` never asserted
- `reset` asserted mid-ARB_BUSY_D while `mem_ready` is low:
  - `mem_req`=0 the same cycle
  - no `d_rvalid`
  - all counters 0
- `d_req` pulsed for one cycle while ARB_BUSY_I:
  - never granted
  - `grants_d` unchanged
- `grants_i` preloaded to 0xFFFF_FFFE, then three fetch transactions:
  - `grants_i` reaches 0xFFFF_FFFF and stays there

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int unsigned CNT_WIDTH = 32;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick between fetch (REQ_I) and data (REQ_D).
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_d,
    output logic       pick,
    output logic       conflict
);

    assign conflict = req[REQ_I] & req[REQ_D];
    // last_d set means the data side is owed the next conflict.
    assign pick     = conflict ? last_d : req[REQ_D];

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-cache transactions onto the single memory port,
// returning read data with a one-cycle valid pulse and keeping grant statistics.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  grants_i,
    output logic [CNT_WIDTH-1:0]  grants_d,
    output logic [CNT_WIDTH-1:0]  conflicts
);

    arb_state_t            state_q, state_d;
    logic                  last_d_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  i_gnt_q, d_gnt_q, i_rvalid_q, d_rvalid_q;
    logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;
    logic [CNT_WIDTH-1:0]  grants_i_q, grants_d_q, conflicts_q;

    logic pick, conflict;
    logic grant_i, grant_d, done;

    arb_rr2 u_rr (
        .req      ({d_req, i_req}),
        .last_d   (last_d_q),
        .pick     (pick),
        .conflict (conflict)
    );

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    if (pick == REQ_D) begin
                        state_d = ARB_BUSY_D;
                        grant_d = 1'b1;
                    end else begin
                        state_d = ARB_BUSY_I;
                        grant_i = 1'b1;
                    end
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (mem_ready) begin
                    state_d = ARB_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            last_d_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            grants_i_q  <= '0;
            grants_d_q  <= '0;
            conflicts_q <= '0;
        end else begin
            state_q    <= state_d;
            i_gnt_q    <= grant_i;
            d_gnt_q    <= grant_d;
            i_rvalid_q <= done && (state_q == ARB_BUSY_I);
            d_rvalid_q <= done && (state_q == ARB_BUSY_D);
            if (grant_i || grant_d) begin
                last_d_q <= grant_i;
                addr_q   <= grant_d ? d_addr : i_addr;
                wdata_q  <= grant_d ? d_wdata : '0;
                we_q     <= grant_d & d_we;
            end
            if (done && (state_q == ARB_BUSY_I)) begin
                i_rdata_q <= mem_rdata;
            end
            if (done && (state_q == ARB_BUSY_D)) begin
                d_rdata_q <= we_q ? '0 : mem_rdata;
            end
            if (grant_i) begin
                grants_i_q <= sat_inc(grants_i_q);
            end
            if (grant_d) begin
                grants_d_q <= sat_inc(grants_d_q);
            end
            if ((grant_i || grant_d) && conflict) begin
                conflicts_q <= sat_inc(conflicts_q);
            end
        end
    end

    // Derived from state so an asynchronous reset drops the request at once.
    assign mem_req   = (state_q != ARB_IDLE);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_gnt     = i_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign grants_i  = grants_i_q;
    assign grants_d  = grants_d_q;
    assign conflicts = conflicts_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences, random vs model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] grants_i, grants_d, conflicts;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .grants_i  (grants_i),
        .grants_d  (grants_d),
        .conflicts (conflicts)
    );

    typedef struct packed {
        logic i_req, d_req, rdy;
        logic ig, dg, ir, dr, mreq;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    endtask

    // Leaves the bench at a negedge with reset just released.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] ctl();
        return 32'({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req});
    endfunction

    // One fetch with mem_ready on the first busy cycle; returns at the idle cycle.
    task automatic run_fetch(input logic [31:0] addr, input logic [31:0] data);
        i_req = 1; i_addr = addr;
        @(negedge clk);
        chk("fetch_gnt", ctl(), 32'b10001);
        i_req = 0; mem_ready = 1; mem_rdata = data;
        @(negedge clk);
        chk("fetch_rvalid", ctl(), 32'b00100);
        chk("fetch_rdata", i_rdata, data);
        mem_ready = 0;
    endtask

    // Reference model: transaction-level view of ownership and statistics.
    int          m_owner, m_last;
    logic        m_we, m_ig, m_dg, m_ir, m_dr;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata, m_gi, m_gd, m_cf;

    function automatic logic [31:0] sat(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_we = 0;
        m_ig = 0; m_dg = 0; m_ir = 0; m_dr = 0;
        m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
        m_gi = 0; m_gd = 0; m_cf = 0;
    endtask

    task automatic model_step();
        int winner;
        m_ig = 0; m_dg = 0; m_ir = 0; m_dr = 0;
        if (m_owner == 0) begin
            winner = 0;
            if (i_req && d_req) begin
                winner = (m_last == 1) ? 2 : 1;
                m_cf   = sat(m_cf);
            end else if (i_req) begin
                winner = 1;
            end else if (d_req) begin
                winner = 2;
            end
            if (winner == 1) begin
                m_addr = i_addr; m_we = 0; m_ig = 1; m_gi = sat(m_gi);
            end else if (winner == 2) begin
                m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_dg = 1; m_gd = sat(m_gd);
            end
            if (winner != 0) begin
                m_owner = winner;
                m_last  = winner;
            end
        end else if (mem_ready) begin
            if (m_owner == 1) begin
                m_ir = 1; m_irdata = mem_rdata;
            end else begin
                m_dr = 1; m_drdata = m_we ? 32'd0 : mem_rdata;
            end
            m_owner = 0;
        end
    endtask

    task automatic rand_run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            chk("rand_ctl", ctl(), 32'({m_ig, m_dg, m_ir, m_dr, m_owner != 0}));
            if (m_owner != 0) begin
                chk("rand_addr", mem_addr, m_addr);
                chk("rand_we", 32'(mem_we), 32'(m_we));
                if (m_owner == 2 && m_we) chk("rand_wdata", mem_wdata, m_wdata);
            end
            if (m_ir) chk("rand_irdata", i_rdata, m_irdata);
            if (m_dr) chk("rand_drdata", d_rdata, m_drdata);
            chk("rand_cnt", grants_i ^ {grants_d[15:0], grants_d[31:16]} ^ (conflicts << 3),
                m_gi ^ {m_gd[15:0], m_gd[31:16]} ^ (m_cf << 3));
            // Requesters hold until granted, with occasional legal withdrawal.
            if (m_ig) i_req = 0;
            else if (!i_req) begin
                i_req = ($urandom_range(0, 2) == 0);
                i_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) i_req = 0;
            if (m_dg) d_req = 0;
            else if (!d_req) begin
                d_req = ($urandom_range(0, 2) == 0);
                d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 15) == 0) d_req = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            model_step();
            @(negedge clk);
        end
        chk("rand_grants_i", grants_i, m_gi);
        chk("rand_grants_d", grants_d, m_gd);
        chk("rand_conflicts", conflicts, m_cf);
    endtask

    vec_t tbl[9];

    initial begin
        reset = 1'b1;
        // Reset state.
        do_reset();
        chk("rst_ctl", ctl() | 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        chk("rst_cnt", grants_i | grants_d | conflicts, 32'd0);

        // Basic fetch with memory stall.
        i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        chk("t1_gnt", ctl(), 32'b10001);
        chk("t1_addr0", mem_addr, 32'h100);
        i_req = 0;
        @(negedge clk);
        chk("t1_busy", ctl(), 32'b00001);
        chk("t1_addr1", mem_addr, 32'h100);
        @(negedge clk);
        chk("t1_addr2", mem_addr, 32'h100);
        chk("t1_we", 32'(mem_we), 32'd0);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_rvalid", ctl(), 32'b00100);
        chk("t1_rdata", i_rdata, 32'hDEAD_BEEF);
        chk("t1_grants_i", grants_i, 32'd1);
        mem_ready = 0;
        @(negedge clk);
        chk("t1_after", ctl(), 32'd0);

        // Conflict table: both held, memory always ready; order I, D, I, D.
        do_reset();
        tbl[0] = '{1, 1, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 0, 0, 1};
        tbl[2] = '{1, 1, 1, 0, 0, 1, 0, 0};
        tbl[3] = '{1, 1, 1, 0, 1, 0, 0, 1};
        tbl[4] = '{1, 1, 1, 0, 0, 0, 1, 0};
        tbl[5] = '{1, 1, 1, 1, 0, 0, 0, 1};
        tbl[6] = '{1, 1, 1, 0, 0, 1, 0, 0};
        tbl[7] = '{1, 1, 1, 0, 1, 0, 0, 1};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        i_addr = 32'h40; d_addr = 32'h80; mem_rdata = 32'h5A5A_0001;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("tbl_row%0d", k), ctl(),
                32'({tbl[k].ig, tbl[k].dg, tbl[k].ir, tbl[k].dr, tbl[k].mreq}));
            i_req = tbl[k].i_req; d_req = tbl[k].d_req; mem_ready = tbl[k].rdy;
            @(negedge clk);
        end
        chk("tbl_conflicts", conflicts, 32'd4);
        chk("tbl_grants", {grants_i[15:0], grants_d[15:0]}, {16'd2, 16'd2});

        // Data write.
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("wr_gnt", ctl(), 32'b01001);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", mem_addr, 32'h20);
        chk("wr_wdata", mem_wdata, 32'h1234_5678);
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("wr_rvalid", ctl(), 32'b00010);
        chk("wr_rdata", d_rdata, 32'd0);
        mem_ready = 0;
        @(negedge clk);
        chk("wr_no_irvalid", 32'(i_rvalid), 32'd0);

        // Reset in the middle of a data read.
        do_reset();
        d_req = 1; d_addr = 32'h44;
        @(negedge clk);
        chk("rr_gnt", ctl(), 32'b01001);
        d_req = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("rr_memreq_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1; mem_rdata = 32'h7777_7777;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rr_no_rvalid", ctl(), 32'd0);
        end
        chk("rr_cnt", grants_i | grants_d | conflicts, 32'd0);
        mem_ready = 0;

        // Data request pulsed while fetch is busy is dropped.
        do_reset();
        i_req = 1; i_addr = 32'h200;
        @(negedge clk);
        chk("pl_gnt", ctl(), 32'b10001);
        i_req = 0; d_req = 1; d_addr = 32'h300;
        @(negedge clk);
        chk("pl_busy", ctl(), 32'b00001);
        d_req = 0;
        @(negedge clk);
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("pl_rvalid", ctl(), 32'b00100);
        mem_ready = 0;
        repeat (2) begin
            @(negedge clk);
            chk("pl_no_dgnt", ctl(), 32'd0);
        end
        chk("pl_grants_d", grants_d, 32'd0);

        // Saturation of grants_i.
        do_reset();
        force dut.grants_i_q = 32'hFFFF_FFFE;
        #1 release dut.grants_i_q;
        @(negedge clk);
        chk("sat_preload", grants_i, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            run_fetch(32'h1000 + 32'(k * 4), 32'hC0DE_0000 + 32'(k));
            chk("sat_grants_i", grants_i, 32'hFFFF_FFFF);
        end

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        rand_run(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
